// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx serial transmitter and its helpers.
package piso_pkg;

  // Frame sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_e;

  // Line levels for the framing bits.
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : piso_pkg

// File: rtl/piso_tx_if.sv
// Parallel-side handshake and serial-side status of the transmitter.
interface piso_tx_if #(
  parameter int DATA_W = 3
);
  logic [DATA_W-1:0] d;      // word to send, sampled on accept
  logic              load;   // source offers a word
  logic              ready;  // transmitter idle, can accept
  logic              tx;     // serial line, idles high
  logic              busy;   // frame in progress
  logic              done;   // one-cycle pulse after stop bit

  // Data source: offers words and watches the transmitter status.
  modport master (
    output d, load,
    input  ready, tx, busy, done
  );

  // Transmitter: takes words and produces the serial line.
  modport slave (
    input  d, load,
    output ready, tx, busy, done
  );
endinterface : piso_tx_if

// File: rtl/piso_tx_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT clocks per serial bit and flags the
// last clock of each period. Shared with the receiving end of the link.
module bit_timer
  import piso_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,    // restart the period from zero
  input  logic en,     // count while a frame is on the line
  output logic tick    // last clock of the current bit period
);

  localparam int              CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // With CLKS_PER_BIT=1 LAST is 0, so every enabled cycle is a tick.
  assign tick = en && (cnt_q == LAST);

  // Next count: clear wins, otherwise advance and wrap at the bit boundary.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking here so all flops update from pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : bit_timer

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: start bit, DATA_W data bits LSB-first,
// stop bit, each held for CLKS_PER_BIT clocks. tx/busy/done are registered.
module piso_tx #(
  parameter int DATA_W       = 3,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic      clk,
  input  logic      reset,   // asynchronous, active-low
  piso_tx_if.slave  bus
);
  import piso_pkg::*;

  localparam int               IDX_W    = cnt_width(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic              tx_q,    tx_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic ready_w;
  logic accept;
  logic timer_en;
  logic bit_tick;

  // Ready depends on state only, so a source may wait on it without a loop.
  assign ready_w   = (state_q == IDLE);
  assign accept    = bus.load && ready_w;
  assign timer_en  = (state_q != IDLE);

  assign bus.ready = ready_w;
  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .rst_n (reset),
    .clr   (accept),
    .en    (timer_en),
    .tick  (bit_tick)
  );

  // Next state, shift register and bit index; loads ignored outside IDLE.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = bus.d;
          idx_d   = '0;
        end
      end
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the next cycle, derived from where the FSM is going so
  // the registered tx changes in the same cycle the state does.
  always_comb begin
    tx_d = IDLE_LEVEL;
    case (state_d)
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = STOP_LEVEL;
      default: tx_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && bit_tick;
  end

  // State, shift register and bit index; reset drops any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  // Registered outputs: line high, not busy, no done while in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_q   <= IDLE_LEVEL;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

endmodule : piso_tx
